// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch program-counter generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_pkg;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    // Source selected for the next PC.
    typedef enum logic [1:0] {
        SRC_SEQ    = 2'd0,
        SRC_BRANCH = 2'd1,
        SRC_JALR   = 2'd2,
        SRC_TRAP   = 2'd3
    } redir_src_e;

    localparam int INSTR_BYTES = 4;
    localparam int REDIR_CNT_W = 16;

endpackage

// File: rtl/pc_hist_buf.sv
// Circular history of redirect source PCs; newest entry is read at index 0.
// Latency: push lands at the next edge, read is combinational.
// Backpressure: none, the oldest entry is overwritten when the buffer is full.
//
// Ports: clk/rst_n (async active-low, clears all entries), push_i/push_pc_i
// write one entry, rd_idx_i selects how far back from the newest, rd_data_o
// returns that entry (zero if never written since reset).
module pc_hist_buf #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [XLEN-1:0]          push_pc_i,
    input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
    output logic [XLEN-1:0]          rd_data_o
);

    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i) begin
            mem_q[wptr_q] <= push_pc_i;
            wptr_q        <= wptr_q + 1'b1;
        end
    end

    // wptr_q points at the next free slot, so the newest entry sits one
    // behind it; DEPTH is a power of two so the subtraction wraps for free.
    assign rd_ptr    = wptr_q - rd_idx_i - AW'(1);
    assign rd_data_o = mem_q[rd_ptr];

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential advance, branch/JALR/trap redirect, halt, misalign detect.
// Latency: selected target appears on PC one edge after the request.
// Backpressure: PC holds while stall=1 or fetch_ready=0 (trap still redirects).
//
// Ports: clk/rst_n (async active-low); stall, fetch_ready gate the step;
// fetch_valid/PC form the fetch request; branch_*/jalr_*/trap_* request
// redirects; halt_req parks the FSM; misalign/misalign_addr report a
// rejected target; redir_cnt counts applied redirects (saturating);
// hist_idx/hist_data read the redirect history when PC_HIST_EN is defined,
// otherwise hist_data is zero and no history storage exists.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 'hBFC00000,
    parameter logic [XLEN-1:0] IMEM_BASE    = 'hBFC00000,
    parameter int              HIST_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          stall,
    input  logic                          fetch_ready,
    output logic                          fetch_valid,
    output logic [XLEN-1:0]               PC,
    input  logic                          branch_en,
    input  logic [XLEN-1:0]               branch_imm,
    input  logic                          jalr_en,
    input  logic [XLEN-1:0]               jalr_target,
    input  logic                          trap_en,
    input  logic [XLEN-1:0]               trap_vector,
    input  logic                          halt_req,
    output logic                          misalign,
    output logic [XLEN-1:0]               misalign_addr,
    output logic [REDIR_CNT_W-1:0]        redir_cnt,
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
    output logic [XLEN-1:0]               hist_data
);

    pc_state_e               state_q, state_d;
    logic [XLEN-1:0]         pc_q, pc_d;
    logic                    mis_q, mis_d;
    logic [XLEN-1:0]         mis_addr_q, mis_addr_d;
    logic [REDIR_CNT_W-1:0]  cnt_q, cnt_d;

    redir_src_e              src;
    logic                    take;
    logic                    step;
    logic                    bad_tgt;
    logic                    redir;
    logic [XLEN-1:0]         jalr_sum;
    logic [XLEN-1:0]         tgt;

    assign step     = (state_q == RUN) && !stall && fetch_ready;
    assign jalr_sum = jalr_target + IMEM_BASE;

    // Source select: trap beats everything outside BOOT, then the step gates
    // JALR > branch > sequential.
    always_comb begin
        src  = SRC_SEQ;
        take = 1'b0;
        if (state_q != BOOT && trap_en) begin
            src  = SRC_TRAP;
            take = 1'b1;
        end else if (step) begin
            take = 1'b1;
            if (jalr_en) begin
                src = SRC_JALR;
            end else if (branch_en) begin
                src = SRC_BRANCH;
            end
        end
    end

    always_comb begin
        case (src)
            SRC_TRAP:   tgt = trap_vector;
            SRC_JALR:   tgt = {jalr_sum[XLEN-1:1], 1'b0};
            SRC_BRANCH: tgt = pc_q + branch_imm;
            default:    tgt = pc_q + XLEN'(INSTR_BYTES);
        endcase
    end

    // Only computed targets are alignment-checked; the trap vector is trusted.
    assign bad_tgt = take && (src == SRC_JALR || src == SRC_BRANCH) && (tgt[1:0] != 2'b00);
    assign redir   = take && (src != SRC_SEQ) && !bad_tgt;

    always_comb begin
        pc_d       = (take && !bad_tgt) ? tgt : pc_q;
        mis_d      = bad_tgt;
        mis_addr_d = bad_tgt ? tgt : mis_addr_q;
        cnt_d      = (redir && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    // FSM next state and outputs.
    always_comb begin
        state_d     = state_q;
        fetch_valid = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                fetch_valid = 1'b1;
                if (trap_en) begin
                    state_d = RUN;
                end else if (halt_req) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (trap_en) begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            mis_q      <= 1'b0;
            mis_addr_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mis_q      <= mis_d;
            mis_addr_q <= mis_addr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign PC            = pc_q;
    assign misalign      = mis_q;
    assign misalign_addr = mis_addr_q;
    assign redir_cnt     = cnt_q;

`ifdef PC_HIST_EN
    pc_hist_buf #(
        .XLEN  (XLEN),
        .DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (redir),
        .push_pc_i (pc_q),
        .rd_idx_i  (hist_idx),
        .rd_data_o (hist_data)
    );
`else
    logic unused_hist_idx;
    assign unused_hist_idx = ^hist_idx;
    assign hist_data       = '0;
`endif

endmodule
